// File: rtl/array_order_checker.sv
// Walks a word array in memory and reports whether neighbouring elements obey the
// configured order. A scan starts from a start pulse or from the CPU reaching a target PC.
// state | meaning
// IDLE  | waiting for a start pulse or an armed PC match
// REQ   | reading element idx and comparing it with the previous element
// DONE  | one-cycle completion pulse, then back to IDLE
module array_order_checker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int DESCENDING = 0,
  parameter int SIGNED     = 0,
  parameter int STRICT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_trig_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] trigger_pc,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LEN_W-1:0]  fail_index
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] prev;
  logic              fired;

  logic              pc_hit;
  logic              go;
  logic              lt;
  logic              eq;
  logic              in_order;
  logic [ADDR_W-1:0] next_addr;

  // Only one scan per arming: the fired flag blocks re-triggering until pc_trig_en drops.
  assign pc_hit    = pc_trig_en && (pc == trigger_pc) && !fired;
  assign go        = (state == IDLE) && (start || pc_hit);
  assign next_addr = base_q + (ADDR_W'(idx + LEN_W'(1)) << 2);

  always_comb begin
    if (SIGNED != 0) lt = $signed(prev) < $signed(mem_rdata);
    else             lt = prev < mem_rdata;
    eq = (prev == mem_rdata);
    if (DESCENDING != 0) in_order = !lt && !((STRICT != 0) && eq);
    else                 in_order = lt || ((STRICT == 0) && eq);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx        <= '0;
      prev       <= '0;
      fired      <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= '0;
    end else begin
      if (!pc_trig_en)                  fired <= 1'b0;
      else if (state == IDLE && pc_hit) fired <= 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            base_q     <= base_addr;
            len_q      <= length;
            idx        <= '0;
            pass       <= 1'b0;
            fail_index <= '0;
            busy       <= 1'b1;
            if (length <= LEN_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state    <= REQ;
              mem_rd   <= 1'b1;
              mem_addr <= base_addr;
            end
          end
        end
        REQ: begin
          if (mem_valid) begin
            prev <= mem_rdata;
            if (idx != '0 && !in_order) begin
              fail_index <= idx;
              mem_rd     <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (idx == len_q - LEN_W'(1)) begin
              pass   <= 1'b1;
              mem_rd <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              idx      <= idx + LEN_W'(1);
              mem_addr <= next_addr;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_order_checker.sv
// Directed bench for array_order_checker: one default-parameter instance with a wait-state
// memory model, plus three variant instances (non-strict, signed, descending) on zero-wait memory.
module tb_array_order_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pc_trig_en = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] trigger_pc = '0;
  logic [31:0] base_addr = '0;
  logic [7:0]  length = '0;

  logic        d_rd, d_valid, d_busy, d_done, d_pass;
  logic [31:0] d_addr, d_rdata;
  logic [7:0]  d_fidx;

  logic [2:0]  s_rd, s_busy, s_done, s_pass;
  logic [31:0] s_addr [3];
  logic [31:0] s_rdata [3];
  logic [7:0]  s_fidx [3];

  logic [31:0] mem [0:1023];
  int          nwait = 0;
  int          wcnt = 0;
  int          done_total = 0;
  int          rd_total = 0;
  int          rd_cyc_total = 0;
  int          addr_glitch = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] held_addr = '0;
  logic [31:0] addr_log [0:1023];

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  assign d_rdata = mem[d_addr[11:2]];
  assign d_valid = d_rd && (wcnt == nwait);

  array_order_checker u_def (
    .clk(clk), .rst(rst), .start(start), .pc_trig_en(pc_trig_en), .pc(pc),
    .trigger_pc(trigger_pc), .base_addr(base_addr), .length(length),
    .mem_rd(d_rd), .mem_addr(d_addr), .mem_rdata(d_rdata), .mem_valid(d_valid),
    .busy(d_busy), .done(d_done), .pass(d_pass), .fail_index(d_fidx)
  );

  array_order_checker #(.STRICT(0)) u_ns (
    .clk(clk), .rst(rst), .start(start), .pc_trig_en(pc_trig_en), .pc(pc),
    .trigger_pc(trigger_pc), .base_addr(base_addr), .length(length),
    .mem_rd(s_rd[0]), .mem_addr(s_addr[0]), .mem_rdata(s_rdata[0]), .mem_valid(1'b1),
    .busy(s_busy[0]), .done(s_done[0]), .pass(s_pass[0]), .fail_index(s_fidx[0])
  );

  array_order_checker #(.SIGNED(1)) u_sg (
    .clk(clk), .rst(rst), .start(start), .pc_trig_en(pc_trig_en), .pc(pc),
    .trigger_pc(trigger_pc), .base_addr(base_addr), .length(length),
    .mem_rd(s_rd[1]), .mem_addr(s_addr[1]), .mem_rdata(s_rdata[1]), .mem_valid(1'b1),
    .busy(s_busy[1]), .done(s_done[1]), .pass(s_pass[1]), .fail_index(s_fidx[1])
  );

  array_order_checker #(.DESCENDING(1)) u_ds (
    .clk(clk), .rst(rst), .start(start), .pc_trig_en(pc_trig_en), .pc(pc),
    .trigger_pc(trigger_pc), .base_addr(base_addr), .length(length),
    .mem_rd(s_rd[2]), .mem_addr(s_addr[2]), .mem_rdata(s_rdata[2]), .mem_valid(1'b1),
    .busy(s_busy[2]), .done(s_done[2]), .pass(s_pass[2]), .fail_index(s_fidx[2])
  );

  assign s_rdata[0] = mem[s_addr[0][11:2]];
  assign s_rdata[1] = mem[s_addr[1][11:2]];
  assign s_rdata[2] = mem[s_addr[2][11:2]];

  // Observes the default instance: done pulses, accepted reads, and address stability.
  always @(posedge clk) begin
    if (d_done) done_total <= done_total + 1;
    if (d_rd) rd_cyc_total <= rd_cyc_total + 1;
    if (d_valid) begin
      addr_log[rd_total[9:0]] <= d_addr;
      rd_total <= rd_total + 1;
    end
    if (d_rd && prev_wait && d_addr != held_addr) addr_glitch <= addr_glitch + 1;
    prev_wait <= d_rd && !d_valid;
    held_addr <= d_addr;
    if (d_rd) wcnt <= d_valid ? 0 : wcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulses start, then counts negedges until done (cycle 1 = the cycle after the start edge).
  // A second start pulse is injected at cycle `poke` when poke > 0.
  task automatic run_scan(input int poke, output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!d_done && cyc < 200) begin
      start = (cyc == poke);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    if (!d_done) cyc = -1;
  endtask

  task automatic load(input int base, input int n, input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3);
    logic [31:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < n; k++) mem[(base >> 2) + k] = v[k];
  endtask

  initial begin
    int cyc;
    int rd0, dn0, rc0;
    int pcs [5];
    pcs = '{84, 88, 88, 92, 88};
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    for (int k = 0; k < 12; k++) mem[128 + k] = 32'(11 * k);

    // Reset values
    #1;
    check("rst_busy", d_busy, 0);
    check("rst_done", d_done, 0);
    check("rst_pass", d_pass, 0);
    check("rst_fidx", d_fidx, 0);
    check("rst_rd", d_rd, 0);
    check("rst_addr", d_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Sorted ascending array, 12 elements at 512
    base_addr = 512; length = 12; rd0 = rd_total;
    run_scan(0, cyc);
    check("asc_latency", cyc, 13);
    check("asc_pass", d_pass, 1);
    check("asc_fidx", d_fidx, 0);
    @(negedge clk);
    check("asc_reads", rd_total - rd0, 12);
    for (int k = 0; k < 12; k++) check("asc_addr", addr_log[rd0 + k], 512 + 4 * k);
    repeat (3) @(negedge clk);
    check("asc_pass_hold", d_pass, 1);

    // Unsorted array: 55,88,0,22 -> fails at index 2 after 3 reads
    load(512, 4, 55, 88, 0, 22);
    rd0 = rd_total;
    run_scan(0, cyc);
    check("uns_latency", cyc, 4);
    check("uns_pass", d_pass, 0);
    check("uns_fidx", d_fidx, 2);
    repeat (3) @(negedge clk);
    check("uns_reads", rd_total - rd0, 3);
    check("uns_fidx_hold", d_fidx, 2);

    // Mode checks on [5,5,7]
    load(1024, 3, 5, 5, 7, 0);
    base_addr = 1024; length = 3;
    run_scan(0, cyc);
    repeat (6) @(negedge clk);
    check("eq_strict_pass", d_pass, 0);
    check("eq_strict_fidx", d_fidx, 1);
    check("eq_nonstrict_pass", s_pass[0], 1);
    check("eq_desc_fidx", s_fidx[2], 1);

    // Mode checks on [-1,3]
    load(1100, 2, 32'hFFFF_FFFF, 3, 0, 0);
    base_addr = 1100; length = 2;
    run_scan(0, cyc);
    repeat (6) @(negedge clk);
    check("neg_unsigned_pass", d_pass, 0);
    check("neg_unsigned_fidx", d_fidx, 1);
    check("neg_signed_pass", s_pass[1], 1);
    check("neg_desc_unsigned_pass", s_pass[2], 1);

    // Mode checks on [9,4,1]
    load(1200, 3, 9, 4, 1, 0);
    base_addr = 1200; length = 3;
    run_scan(0, cyc);
    repeat (6) @(negedge clk);
    check("desc_pass", s_pass[2], 1);
    check("desc_asc_fidx", d_fidx, 1);

    // Wait states with a start pulse while busy
    load(512, 4, 0, 11, 22, 33);
    base_addr = 512; length = 4; nwait = 2;
    dn0 = done_total; rd0 = rd_total;
    run_scan(4, cyc);
    check("wait_latency", cyc, 13);
    check("wait_pass", d_pass, 1);
    repeat (20) @(negedge clk);
    check("wait_addr_stable", addr_glitch, 0);
    check("wait_reads", rd_total - rd0, 4);
    check("busy_start_ignored", done_total - dn0, 1);
    check("busy_idle", d_busy, 0);
    nwait = 0;

    // PC trigger: one scan per arming
    base_addr = 512; length = 2;
    trigger_pc = 88; pc = 84; dn0 = done_total;
    @(negedge clk); pc_trig_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc = pcs[k];
      repeat (4) @(negedge clk);
    end
    check("pc_one_scan", done_total - dn0, 1);
    pc_trig_en = 1'b0;
    repeat (2) @(negedge clk);
    pc_trig_en = 1'b1;
    repeat (8) @(negedge clk);
    check("pc_rearm_scan", done_total - dn0, 2);
    pc_trig_en = 1'b0;
    @(negedge clk);
    pc_trig_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("pc_and_start_single", done_total - dn0, 3);
    pc_trig_en = 1'b0; pc = 0;

    // Reset while element 5 is outstanding
    load(512, 4, 0, 11, 22, 33);
    length = 12; dn0 = done_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rd_before_rst", d_addr, 532);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", d_busy, 0);
    check("mid_rst_rd", d_rd, 0);
    check("mid_rst_addr", d_addr, 0);
    check("mid_rst_pass", d_pass, 0);
    check("mid_rst_done", d_done, 0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", done_total - dn0, 0);

    // Short arrays: no memory traffic, done one cycle after start
    length = 1; rc0 = rd_cyc_total;
    run_scan(0, cyc);
    check("len1_latency", cyc, 1);
    check("len1_pass", d_pass, 1);
    length = 0;
    run_scan(0, cyc);
    check("len0_latency", cyc, 1);
    check("len0_pass", d_pass, 1);
    repeat (3) @(negedge clk);
    check("short_no_rd", rd_cyc_total - rc0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
